cl2_pl_exu_wbck: RTL and testbench

Write-back stage of the CL2 pipelined EXU, and the writer side of the integer register file.
- Accepts results from three producers (ALU, LSU, MDU) over valid/ready handshakes.
- Arbitrates to a single registered write port that drives the regfile wd_wen/wd_idx/wd_dat inputs.
- Maintains a scoreboard of destinations with outstanding long-latency writes, used by issue for hazard stalls.

---
 rtl/cl2_pl_exu_wbck.sv | 100 ++++++++++
 tb/tb_cl2_pl_exu_wbck.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cl2_pl_exu_wbck.sv
// CL2 pipelined EXU write-back stage: arbitrates ALU/LSU/MDU results onto the
// single regfile write port and tracks pending long-latency destinations.
module cl2_pl_exu_wbck #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned REG_WIDTH  = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [REG_WIDTH-1:0] alu_idx_i,
  input  logic [XLEN-1:0]      alu_dat_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [REG_WIDTH-1:0] lsu_idx_i,
  input  logic [XLEN-1:0]      lsu_dat_i,
  input  logic                 mdu_valid_i,
  output logic                 mdu_ready_o,
  input  logic [REG_WIDTH-1:0] mdu_idx_i,
  input  logic [XLEN-1:0]      mdu_dat_i,
  input  logic                 sb_set_i,
  input  logic [REG_WIDTH-1:0] sb_idx_i,
  output logic [REG_NUM-1:0]   sb_busy_o,
  output logic                 wd_wen_o,
  output logic [REG_WIDTH-1:0] wd_idx_o,
  output logic [XLEN-1:0]      wd_dat_o
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LSU, SRC_MDU} src_e;

  src_e                 grant;
  logic [CW-1:0]        starve_cnt;
  logic                 alu_first;
  logic [REG_WIDTH-1:0] win_idx;
  logic [XLEN-1:0]      win_dat;
  logic                 win_clr;
  logic [REG_NUM-1:0]   busy_next;

  assign alu_first = (starve_cnt == CW'(STARVE_MAX));

  // Ready is gated by rst_i so a handshake during reset is never accepted.
  always_comb begin
    grant = SRC_NONE;
    if (!rst_i) begin
      if (alu_first && alu_valid_i) grant = SRC_ALU;
      else if (lsu_valid_i)         grant = SRC_LSU;
      else if (mdu_valid_i)         grant = SRC_MDU;
      else if (alu_valid_i)         grant = SRC_ALU;
    end
  end

  assign alu_ready_o = (grant == SRC_ALU);
  assign lsu_ready_o = (grant == SRC_LSU);
  assign mdu_ready_o = (grant == SRC_MDU);

  always_comb begin
    win_idx = alu_idx_i;
    win_dat = alu_dat_i;
    win_clr = 1'b0;
    case (grant)
      SRC_LSU: begin win_idx = lsu_idx_i; win_dat = lsu_dat_i; win_clr = 1'b1; end
      SRC_MDU: begin win_idx = mdu_idx_i; win_dat = mdu_dat_i; win_clr = 1'b1; end
      default: ;
    endcase
  end

  // Clear is applied before set so a same-index set/clear leaves the bit busy.
  always_comb begin
    busy_next = sb_busy_o;
    if (win_clr)  busy_next[win_idx]  = 1'b0;
    if (sb_set_i) busy_next[sb_idx_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
      sb_busy_o  <= '0;
      wd_wen_o   <= 1'b0;
      wd_idx_o   <= '0;
      wd_dat_o   <= '0;
    end else begin
      if (!alu_valid_i || alu_ready_o) starve_cnt <= '0;
      else if (!alu_first)             starve_cnt <= starve_cnt + CW'(1);
      sb_busy_o <= busy_next;
      if (grant != SRC_NONE) begin
        wd_wen_o <= (win_idx != '0);
        wd_idx_o <= win_idx;
        wd_dat_o <= win_dat;
      end else begin
        wd_wen_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cl2_pl_exu_wbck.sv
// Scoreboard bench for cl2_pl_exu_wbck: directed scenarios plus randomized
// producer traffic, checked against a behavioural write-back model.
module tb_cl2_pl_exu_wbck;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, mdu_valid = 1'b0;
  logic        alu_ready, lsu_ready, mdu_ready;
  logic [4:0]  alu_idx = '0, lsu_idx = '0, mdu_idx = '0, sb_idx = '0;
  logic [31:0] alu_dat = '0, lsu_dat = '0, mdu_dat = '0;
  logic        sb_set = 1'b0;
  logic [31:0] sb_busy;
  logic        wd_wen;
  logic [4:0]  wd_idx;
  logic [31:0] wd_dat;

  cl2_pl_exu_wbck #(.XLEN(32), .REG_NUM(32), .REG_WIDTH(5), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_idx_i(alu_idx), .alu_dat_i(alu_dat),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_idx_i(lsu_idx), .lsu_dat_i(lsu_dat),
    .mdu_valid_i(mdu_valid), .mdu_ready_o(mdu_ready), .mdu_idx_i(mdu_idx), .mdu_dat_i(mdu_dat),
    .sb_set_i(sb_set), .sb_idx_i(sb_idx), .sb_busy_o(sb_busy),
    .wd_wen_o(wd_wen), .wd_idx_o(wd_idx), .wd_dat_o(wd_dat)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [4:0] idx; logic [31:0] dat;} wr_t;
  wr_t         q[$];
  int          cyc = 0;
  int          n_cmp = 0, n_fail = 0;
  logic [31:0] mbusy = '0;
  int          mstarve = 0;
  logic [2:0]  last_rdy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each regfile write must match the oldest expected write, in its cycle.
  always @(negedge clk) begin
    wr_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missing_write", 64'(e.cyc), 64'(cyc));
    end
    if (wd_wen) begin
      if (q.size() == 0) check("unexpected_write", {27'd0, wd_idx, wd_dat}, 64'd0);
      else begin
        e = q.pop_front();
        check("write_cycle", 64'(cyc), 64'(e.cyc));
        check("write_idx", 64'(wd_idx), 64'(e.idx));
        check("write_dat", 64'(wd_dat), 64'(e.dat));
      end
    end
  end

  // One clock of the reference model: pick the winner from the priority list,
  // compare readies/busy, then record the resulting write and scoreboard change.
  task automatic cycle();
    int         order[3];
    int         win;
    logic       v[3];
    logic [2:0] exp_rdy;
    logic [4:0] widx;
    logic [31:0] wdat;
    @(negedge clk);
    last_rdy = {alu_ready, lsu_ready, mdu_ready};
    v = '{alu_valid, lsu_valid, mdu_valid};
    if (mstarve == STARVE_MAX) order = '{0, 1, 2};
    else                       order = '{1, 2, 0};
    win = -1;
    if (!rst) for (int k = 0; k < 3; k++) if (win < 0 && v[order[k]]) win = order[k];
    exp_rdy = (win == 0) ? 3'b100 : (win == 1) ? 3'b010 : (win == 2) ? 3'b001 : 3'b000;
    check("ready", 64'(last_rdy), 64'(exp_rdy));
    check("busy", 64'(sb_busy), 64'(mbusy));
    if (!rst) begin
      if (win >= 0) begin
        widx = (win == 0) ? alu_idx : (win == 1) ? lsu_idx : mdu_idx;
        wdat = (win == 0) ? alu_dat : (win == 1) ? lsu_dat : mdu_dat;
        if (widx != 0) q.push_back(wr_t'{cyc + 1, widx, wdat});
        if (win > 0) mbusy[widx] = 1'b0;
      end
      if (sb_set && sb_idx != 0) mbusy[sb_idx] = 1'b1;
      if (alu_valid && win != 0) mstarve = (mstarve < STARVE_MAX) ? mstarve + 1 : STARVE_MAX;
      else                       mstarve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0; sb_set = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_seq[6];
    exp_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b010};

    // Reset state
    repeat (2) cycle();
    check("rst_wen", 64'(wd_wen), 64'd0);
    check("rst_idx", 64'(wd_idx), 64'd0);
    check("rst_dat", 64'(wd_dat), 64'd0);
    check("rst_busy", 64'(sb_busy), 64'd0);
    rst = 1'b0;

    // 1: single ALU write
    alu_valid = 1'b1; alu_idx = 5'd3; alu_dat = 32'hDEADBEEF;
    cycle();
    check("t1_ready", 64'(last_rdy), 64'(3'b100));
    alu_valid = 1'b0;
    check("t1_wen", 64'(wd_wen), 64'd1);
    cycle();
    check("t1_wen_drop", 64'(wd_wen), 64'd0);

    // 2: all producers valid every cycle, ALU starves then wins once
    alu_valid = 1'b1; lsu_valid = 1'b1; mdu_valid = 1'b1;
    alu_idx = 5'd1; lsu_idx = 5'd2; mdu_idx = 5'd4;
    alu_dat = $urandom; lsu_dat = $urandom; mdu_dat = $urandom;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("t2_grant", 64'(last_rdy), 64'(exp_seq[i]));
      if (last_rdy[2]) alu_dat = $urandom;
      if (last_rdy[1]) lsu_dat = $urandom;
      if (last_rdy[0]) mdu_dat = $urandom;
    end
    drive_idle();
    cycle();

    // 3: scoreboard set, MDU return three cycles later
    sb_set = 1'b1; sb_idx = 5'd7;
    cycle();
    sb_set = 1'b0;
    repeat (2) cycle();
    check("t3_busy_held", 64'(sb_busy[7]), 64'd1);
    mdu_valid = 1'b1; mdu_idx = 5'd7; mdu_dat = 32'h1234_5678;
    cycle();
    mdu_valid = 1'b0;
    check("t3_busy_clr", 64'(sb_busy[7]), 64'd0);
    check("t3_wen", 64'(wd_wen), 64'd1);
    check("t3_idx", 64'(wd_idx), 64'd7);

    // 4: set and clear of the same index: set wins, write still happens
    sb_set = 1'b1; sb_idx = 5'd5;
    lsu_valid = 1'b1; lsu_idx = 5'd5; lsu_dat = 32'hCAFE_0005;
    cycle();
    drive_idle();
    check("t4_busy", 64'(sb_busy[5]), 64'd1);
    check("t4_wen", 64'(wd_wen), 64'd1);
    check("t4_idx", 64'(wd_idx), 64'd5);

    // 5: index 0 is consumed without a write and never marked busy
    alu_valid = 1'b1; alu_idx = 5'd0; alu_dat = 32'hFFFF_0000;
    sb_set = 1'b1; sb_idx = 5'd0;
    cycle();
    check("t5_ready", 64'(last_rdy), 64'(3'b100));
    drive_idle();
    check("t5_wen", 64'(wd_wen), 64'd0);
    check("t5_busy0", 64'(sb_busy[0]), 64'd0);
    cycle();

    // Randomized traffic; producers hold until accepted
    for (int n = 0; n < 400; n++) begin
      if (!alu_valid || last_rdy[2]) begin
        alu_valid = ($urandom_range(0, 99) < 50); alu_idx = 5'($urandom); alu_dat = $urandom;
      end
      if (!lsu_valid || last_rdy[1]) begin
        lsu_valid = ($urandom_range(0, 99) < 40); lsu_idx = 5'($urandom); lsu_dat = $urandom;
      end
      if (!mdu_valid || last_rdy[0]) begin
        mdu_valid = ($urandom_range(0, 99) < 30); mdu_idx = 5'($urandom); mdu_dat = $urandom;
      end
      sb_set = ($urandom_range(0, 99) < 30);
      sb_idx = 5'($urandom);
      cycle();
    end
    drive_idle();
    repeat (2) cycle();

    // 6: asynchronous reset the cycle after a handshake kills the pending write
    sb_set = 1'b1; sb_idx = 5'd12;
    cycle();
    sb_set = 1'b0;
    lsu_valid = 1'b1; lsu_idx = 5'd9; lsu_dat = 32'hA5A5_1234;
    cycle();
    lsu_idx = 5'd10; lsu_dat = 32'h0BAD_F00D;
    #2;
    check("t6_pre_wen", 64'(wd_wen), 64'd1);
    check("t6_pre_busy", 64'(sb_busy[12]), 64'd1);
    rst = 1'b1;
    q.delete();
    mbusy = '0;
    mstarve = 0;
    #1;
    check("t6_wen", 64'(wd_wen), 64'd0);
    check("t6_dat", 64'(wd_dat), 64'd0);
    check("t6_busy", 64'(sb_busy), 64'd0);
    check("t6_ready", 64'(lsu_ready), 64'd0);
    repeat (2) cycle();
    rst = 1'b0;
    drive_idle();
    repeat (3) cycle();
    check("t6_no_write", 64'(wd_wen), 64'd0);

    check("queue_drain", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
